// File: rtl/dropout_grad_gate.sv
// Backward-pass dropout gate: queues forward keep-masks in a FIFO and applies the head
// mask to the returning gradient stream, with inverted-dropout rescaling and saturation.
module dropout_grad_gate #(
    parameter int N_NEURONS   = 8,
    parameter int DATA_W      = 8,
    parameter int MASK_DEPTH  = 4,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 mask_wr,
    input  logic [N_NEURONS-1:0] mask_in,
    input  logic                 grad_valid,
    input  logic [DATA_W-1:0]    grad_in,
    output logic                 grad_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 overflow
);
    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int AW = (MASK_DEPTH > 1) ? $clog2(MASK_DEPTH) : 1;
    localparam int CW = $clog2(MASK_DEPTH + 1);
    localparam int WW = DATA_W + SCALE_SHIFT;
    localparam logic signed [WW-1:0] SAT_MAX = WW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {S_WAIT, S_STREAM} state_t;

    state_t               r_state;
    logic [IW-1:0]        r_idx;
    logic [N_NEURONS-1:0] r_mem [MASK_DEPTH];
    logic [AW-1:0]        r_wp, r_rp;
    logic [CW-1:0]        r_cnt;
    logic                 r_ovf;
    logic                 r_out_valid, r_out_last;
    logic [DATA_W-1:0]    r_out_data;

    logic                 w_accept, w_last, w_pop, w_push, w_full, w_empty;
    logic [CW-1:0]        w_cnt_nxt;
    logic [N_NEURONS-1:0] w_head;
    logic signed [WW-1:0] w_wide;
    logic [DATA_W-1:0]    w_sat, w_elem;

    assign w_full     = (r_cnt == CW'(MASK_DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign grad_ready = (r_state == S_STREAM) && ena && (!r_out_valid || out_ready);
    assign w_accept   = grad_valid && grad_ready;
    assign w_last     = (r_idx == IW'(N_NEURONS - 1));
    assign w_pop      = w_accept && w_last;
    // A push into a full FIFO is only legal when the head retires in the same cycle.
    assign w_push     = ena && mask_wr && (!w_full || w_pop);
    assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);

    assign w_head = r_mem[r_rp];
    assign w_wide = {{SCALE_SHIFT{grad_in[DATA_W-1]}}, grad_in} <<< SCALE_SHIFT;

    always_comb begin
        w_sat = w_wide[DATA_W-1:0];
        if (w_wide > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
        else if (w_wide < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
    end

    assign w_elem = w_head[r_idx] ? w_sat : '0;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= mask_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_cnt <= w_cnt_nxt;
            if (ena && mask_wr && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_WAIT;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_idx <= '0;
                    if (!w_empty) r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_idx <= '0;
                            if (w_cnt_nxt == '0) r_state <= S_WAIT;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                default: r_state <= S_WAIT;
            endcase

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_elem;
                r_out_last  <= w_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_dropout_grad_gate.sv
// Directed bench for dropout_grad_gate: gating, saturation, FIFO limits,
// back-pressure/enable stalls and asynchronous reset mid-vector.
module tb_dropout_grad_gate;
    logic       clk = 1'b0;
    logic       rst_n, ena, mask_wr, grad_valid, out_ready;
    logic [7:0] mask_in, grad_in;
    logic       grad_ready, out_valid, out_last, fifo_empty, fifo_full, overflow;
    logic [7:0] out_data;

    int n_chk = 0;
    int n_pass = 0;
    logic signed [7:0] gv [8];
    logic signed [7:0] ev [8];

    dropout_grad_gate #(.N_NEURONS(8), .DATA_W(8), .MASK_DEPTH(4), .SCALE_SHIFT(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mask_wr(mask_wr), .mask_in(mask_in),
        .grad_valid(grad_valid), .grad_in(grad_in), .grad_ready(grad_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; mask_wr = 1'b0; mask_in = '0;
        grad_valid = 1'b0; grad_in = '0; out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic push(input logic [7:0] m);
        mask_in = m; mask_wr = 1'b1;
        step();
        mask_wr = 1'b0;
    endtask

    // Offer one element, wait (bounded) for acceptance, then check the registered output.
    task automatic put(input logic [7:0] g, input logic [7:0] e, input logic last,
                       input logic pm, input logic [7:0] pmask);
        int t;
        grad_valid = 1'b1; grad_in = g; mask_wr = pm; mask_in = pmask;
        #1;
        t = 0;
        while (!grad_ready && t < 50) begin step(); t++; end
        chk("accept_timeout", 32'(t < 50), 32'(1));
        step();
        grad_valid = 1'b0; mask_wr = 1'b0;
        chk("out_valid", 32'(out_valid), 32'(1));
        chk("out_data", {24'd0, out_data}, {24'd0, e});
        chk("out_last", 32'(out_last), 32'(last));
    endtask

    task automatic vec();
        for (int i = 0; i < 8; i++) put(gv[i], ev[i], i == 7, 1'b0, 8'h00);
    endtask

    // Gradients 1..8 never saturate, so the expected value is simply 2*g or 0.
    task automatic fill(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            gv[i] = 8'(i + 1);
            ev[i] = m[i] ? 8'(2 * (i + 1)) : 8'sd0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_grad_ready", 32'(grad_ready), 0);

        // Basic gating
        push(8'b1010_0101);
        chk("push_nonempty", 32'(fifo_empty), 0);
        gv = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
        ev = '{8'sd2, 8'sd0, 8'sd6, 8'sd0, 8'sd0, 8'sd12, 8'sd0, 8'sd16};
        vec();
        chk("basic_empty", 32'(fifo_empty), 1);
        chk("basic_idle", 32'(grad_ready), 0);

        // Saturation
        push(8'hFF);
        gv = '{8'sd100, -8'sd100, 8'sd63, -8'sd64, 8'sd64, -8'sd65, 8'sd127, -8'sd128};
        ev = '{8'sd127, -8'sd128, 8'sd126, -8'sd128, 8'sd127, -8'sd128, 8'sd127, -8'sd128};
        vec();

        // FIFO full and overflow
        do_reset();
        push(8'h01); push(8'h80); push(8'h0F);
        chk("full_at3", 32'(fifo_full), 0);
        push(8'hF0);
        chk("full_at4", 32'(fifo_full), 1);
        chk("ovf_at4", 32'(overflow), 0);
        push(8'hFF);
        chk("full_at5", 32'(fifo_full), 1);
        chk("ovf_at5", 32'(overflow), 1);
        fill(8'h01); vec();
        fill(8'h80); vec();
        fill(8'h0F); vec();
        fill(8'hF0); vec();
        chk("drain_empty", 32'(fifo_empty), 1);
        grad_valid = 1'b1; grad_in = 8'd9;
        #1;
        chk("drain_ready0", 32'(grad_ready), 0);
        step();
        chk("drain_ready1", 32'(grad_ready), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        grad_valid = 1'b0;

        // Push and pop in the same cycle while full
        do_reset();
        push(8'hFF); push(8'h00); push(8'hAA); push(8'h55);
        fill(8'hFF);
        for (int i = 0; i < 7; i++) put(gv[i], ev[i], 1'b0, 1'b0, 8'h00);
        put(gv[7], ev[7], 1'b1, 1'b1, 8'h0F);
        chk("pp_full", 32'(fifo_full), 1);
        chk("pp_ovf", 32'(overflow), 0);
        fill(8'h00); vec();
        fill(8'hAA); vec();
        fill(8'h55); vec();
        fill(8'h0F); vec();
        chk("pp_empty", 32'(fifo_empty), 1);

        // Back-pressure and enable
        do_reset();
        push(8'hFF);
        put(8'd1, 8'd2, 1'b0, 1'b0, 8'h00);
        put(8'd2, 8'd4, 1'b0, 1'b0, 8'h00);
        out_ready = 1'b0; grad_valid = 1'b1; grad_in = 8'd3;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_ready", 32'(grad_ready), 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", {24'd0, out_data}, 4);
            step();
        end
        out_ready = 1'b1;
        put(8'd3, 8'd6, 1'b0, 1'b0, 8'h00);
        ena = 1'b0; grad_valid = 1'b1; grad_in = 8'd4;
        #1;
        chk("ena_ready0", 32'(grad_ready), 0);
        step();
        chk("ena_drain", 32'(out_valid), 0);
        chk("ena_ready1", 32'(grad_ready), 0);
        step();
        ena = 1'b1;
        for (int i = 4; i <= 8; i++) put(8'(i), 8'(2 * i), i == 8, 1'b0, 8'h00);

        // Asynchronous reset mid-vector
        do_reset();
        push(8'hFF); push(8'hFF);
        put(8'd1, 8'd2, 1'b0, 1'b0, 8'h00);
        put(8'd2, 8'd4, 1'b0, 1'b0, 8'h00);
        put(8'd3, 8'd6, 1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", {24'd0, out_data}, 0);
        chk("arst_last", 32'(out_last), 0);
        chk("arst_empty", 32'(fifo_empty), 1);
        chk("arst_full", 32'(fifo_full), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_ready", 32'(grad_ready), 0);
        step();
        rst_n = 1'b1;
        grad_valid = 1'b1; grad_in = 8'd5;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post_rst_ready", 32'(grad_ready), 0);
        end
        grad_valid = 1'b0;
        push(8'hFF);
        fill(8'hFF);
        vec();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
